// File: rtl/iq_decim_pkg.sv
// Shared defaults and width helpers for the IQ decimating averager.
// Optional rounding is enabled by defining IQ_DECIM_ROUND_EN.
package iq_decim_pkg;

  localparam int DW_DEFAULT       = 14;
  localparam int LOG2_MAX_DEFAULT = 4;

  // Sized so a full block of 2^LOG2_MAX extreme samples (plus rounding bias) cannot wrap.
  function automatic int acc_width(input int dw, input int log2_max);
    return dw + log2_max;
  endfunction

  function automatic int log2_dec_width(input int log2_max);
    return $clog2(log2_max + 1);
  endfunction

  localparam int LOG2_DEC_W = $clog2(LOG2_MAX_DEFAULT + 1);

endpackage

// File: rtl/iq_decim_acc.sv
// One-channel block accumulator with arithmetic-shift output stage.
// Defining IQ_DECIM_ROUND_EN adds a round-half-up bias of 2^(k-1) before the shift.
module iq_decim_acc
  import iq_decim_pkg::*;
#(
  parameter int DW       = DW_DEFAULT,
  parameter int LOG2_MAX = LOG2_MAX_DEFAULT
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  en,
  input  logic                                  first,
  input  logic                                  last,
  input  logic [log2_dec_width(LOG2_MAX)-1:0]   k,
  input  logic signed [DW-1:0]                  sample,
  output logic signed [DW-1:0]                  avg
);

  localparam int AW = acc_width(DW, LOG2_MAX);

  logic signed [AW-1:0] acc_q, acc_d;
  logic signed [AW-1:0] sample_ext;
  logic signed [AW-1:0] sum;
  logic signed [AW-1:0] biased;
  logic signed [AW-1:0] shifted;
  logic signed [DW-1:0] avg_q, avg_d;

`ifdef IQ_DECIM_ROUND_EN
  logic [AW-1:0] bias;
  // Half an LSB of the output scale; shifting back down makes k=0 give zero bias.
  always_comb begin
    bias   = (AW'(1) << k) >> 1;
    biased = sum + $signed(bias);
  end
`else
  always_comb begin
    biased = sum;
  end
`endif

  // The first sample of a block reloads the sum so no clearing cycle is needed.
  always_comb begin
    sample_ext = {{LOG2_MAX{sample[DW-1]}}, sample};
    sum        = first ? sample_ext : acc_q + sample_ext;
    shifted    = biased >>> k;
    acc_d      = en ? sum : acc_q;
    avg_d      = (en && last) ? shifted[DW-1:0] : avg_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      avg_q <= '0;
    end else begin
      acc_q <= acc_d;
      avg_q <= avg_d;
    end
  end

  assign avg = avg_q;

endmodule

// File: rtl/iq_decim_avg.sv
// IQ decimating block averager: sums 2^k samples per channel and outputs the scaled mean.
// Rounding is selected by defining IQ_DECIM_ROUND_EN; default build truncates.
module iq_decim_avg
  import iq_decim_pkg::*;
#(
  parameter int DW       = DW_DEFAULT,
  parameter int LOG2_MAX = LOG2_MAX_DEFAULT
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  restart,
  input  logic [log2_dec_width(LOG2_MAX)-1:0]   log2_dec,
  input  logic                                  in_valid,
  input  logic signed [DW-1:0]                  in_I,
  input  logic signed [DW-1:0]                  in_Q,
  output logic                                  out_valid,
  output logic signed [DW-1:0]                  out_I,
  output logic signed [DW-1:0]                  out_Q
);

  localparam int KW = log2_dec_width(LOG2_MAX);
  localparam int CW = (LOG2_MAX > 0) ? LOG2_MAX : 1;
  localparam logic [KW-1:0] K_MAX = KW'(LOG2_MAX);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [KW-1:0] k_q, k_d;
  logic          out_valid_q, out_valid_d;

  logic [KW-1:0] k_new;
  logic [KW-1:0] k_eff;
  logic [CW-1:0] idx;
  logic [CW-1:0] last_idx;
  logic          first;
  logic          last;

  // A restart makes the current sample index 0, so the old block can never reach its strobe.
  always_comb begin
    k_new    = (log2_dec > K_MAX) ? K_MAX : log2_dec;
    first    = restart || (cnt_q == '0);
    k_eff    = first ? k_new : k_q;
    idx      = first ? '0 : cnt_q;
    last_idx = CW'((32'd1 << k_eff) - 32'd1);
    last     = (idx == last_idx);

    cnt_d       = cnt_q;
    k_d         = k_q;
    out_valid_d = 1'b0;
    if (in_valid) begin
      k_d         = k_eff;
      cnt_d       = last ? '0 : idx + CW'(1);
      out_valid_d = last;
    end else if (restart) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      k_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      k_q         <= k_d;
      out_valid_q <= out_valid_d;
    end
  end

  iq_decim_acc #(.DW(DW), .LOG2_MAX(LOG2_MAX)) u_acc_i (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (in_valid),
    .first  (first),
    .last   (last),
    .k      (k_eff),
    .sample (in_I),
    .avg    (out_I)
  );

  iq_decim_acc #(.DW(DW), .LOG2_MAX(LOG2_MAX)) u_acc_q (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (in_valid),
    .first  (first),
    .last   (last),
    .k      (k_eff),
    .sample (in_Q),
    .avg    (out_Q)
  );

  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_iq_decim_avg.sv
// Directed bench for iq_decim_avg; expected averages are hand-computed per scenario.
// Expectations for the rounded build follow IQ_DECIM_ROUND_EN.
module tb_iq_decim_avg;

  logic                clk;
  logic                rst_n;
  logic                restart;
  logic [2:0]          log2_dec;
  logic                in_valid;
  logic signed [13:0]  in_I;
  logic signed [13:0]  in_Q;
  logic                out_valid;
  logic signed [13:0]  out_I;
  logic signed [13:0]  out_Q;

  int vectors;
  int miscompares;

  iq_decim_avg #(.DW(14), .LOG2_MAX(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .restart   (restart),
    .log2_dec  (log2_dec),
    .in_valid  (in_valid),
    .in_I      (in_I),
    .in_Q      (in_Q),
    .out_valid (out_valid),
    .out_I     (out_I),
    .out_Q     (out_Q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input integer obs, input integer exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Drives one cycle of inputs at a falling edge and returns at the next falling edge.
  task automatic applyStimulus(input bit v, input int i, input int q, input bit rs, input int k);
    in_valid = v;
    in_I     = 14'(i);
    in_Q     = 14'(q);
    restart  = rs;
    log2_dec = 3'(k);
    @(negedge clk);
  endtask

  task automatic step(input string tag, input bit v, input int i, input int q,
                      input bit rs, input int k, input bit exp_valid);
    applyStimulus(v, i, q, rs, k);
    checkOutput(tag, out_valid, exp_valid);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    restart     = 1'b0;
    log2_dec    = 3'd0;
    in_valid    = 1'b0;
    in_I        = '0;
    in_Q        = '0;

    @(negedge clk);
    @(negedge clk);
    checkOutput("reset_valid", out_valid, 0);
    checkOutput("reset_I", out_I, 0);
    checkOutput("reset_Q", out_Q, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // k=2 ramp: sum I=10 -> 2, sum Q=-10 -> -3 truncated or -2 rounded
    step("ramp_s1", 1'b1, 1, -1, 1'b0, 2, 1'b0);
    step("ramp_s2", 1'b1, 2, -2, 1'b0, 2, 1'b0);
    step("ramp_s3", 1'b1, 3, -3, 1'b0, 2, 1'b0);
    step("ramp_s4", 1'b1, 4, -4, 1'b0, 2, 1'b1);
    checkOutput("ramp_I", out_I, 2);
`ifdef IQ_DECIM_ROUND_EN
    checkOutput("ramp_Q", out_Q, -2);
`else
    checkOutput("ramp_Q", out_Q, -3);
`endif
    step("ramp_idle", 1'b0, 0, 0, 1'b0, 2, 1'b0);
    checkOutput("ramp_hold_I", out_I, 2);

    // k=0 pass-through, back to back
    step("k0_a", 1'b1, 5, -7, 1'b0, 0, 1'b1);
    checkOutput("k0_a_I", out_I, 5);
    checkOutput("k0_a_Q", out_Q, -7);
    step("k0_b", 1'b1, 100, -200, 1'b0, 0, 1'b1);
    checkOutput("k0_b_I", out_I, 100);
    checkOutput("k0_b_Q", out_Q, -200);

    // k=4 full-scale extremes must not wrap
    for (int n = 0; n < 16; n++) begin
      step($sformatf("full_s%0d", n), 1'b1, 8191, -8192, 1'b0, 4, n == 15);
    end
    checkOutput("full_I", out_I, 8191);
    checkOutput("full_Q", out_Q, -8192);

    // k=2 with three idle cycles between valid samples
    for (int n = 0; n < 4; n++) begin
      step($sformatf("gap_v%0d", n), 1'b1, 1, 1, 1'b0, 2, n == 3);
      if (n == 3) begin
        checkOutput("gap_I", out_I, 1);
      end
      for (int g = 0; g < 3; g++) begin
        step($sformatf("gap_idle%0d_%0d", n, g), 1'b0, 0, 0, 1'b0, 2, 1'b0);
      end
    end

    // k changed mid-block: 2-sample block closes on old k, next uses k=3
    step("kchg_s1", 1'b1, 2, 2, 1'b0, 1, 1'b0);
    step("kchg_s2", 1'b1, 4, 4, 1'b0, 3, 1'b1);
    checkOutput("kchg_blk1_I", out_I, 3);
    for (int n = 0; n < 8; n++) begin
      step($sformatf("kchg_b2_s%0d", n), 1'b1, 10, -10, 1'b0, 3, n == 7);
    end
    checkOutput("kchg_blk2_I", out_I, 10);
    checkOutput("kchg_blk2_Q", out_Q, -10);

    // restart with the 3rd sample of a k=2 block
    step("rs3_s1", 1'b1, 100, 100, 1'b0, 2, 1'b0);
    step("rs3_s2", 1'b1, 100, 100, 1'b0, 2, 1'b0);
    step("rs3_s3", 1'b1, 4, -4, 1'b1, 2, 1'b0);
    for (int n = 0; n < 3; n++) begin
      step($sformatf("rs3_post%0d", n), 1'b1, 4, -4, 1'b0, 2, n == 2);
    end
    checkOutput("rs3_I", out_I, 4);
    checkOutput("rs3_Q", out_Q, -4);

    // restart on the would-be closing sample suppresses that block
    for (int n = 0; n < 3; n++) begin
      step($sformatf("rs4_pre%0d", n), 1'b1, 50, 50, 1'b0, 2, 1'b0);
    end
    step("rs4_s4", 1'b1, 8, 8, 1'b1, 2, 1'b0);
    for (int n = 0; n < 3; n++) begin
      step($sformatf("rs4_post%0d", n), 1'b1, 8, 8, 1'b0, 2, n == 2);
    end
    checkOutput("rs4_I", out_I, 8);

    // log2_dec above the maximum clamps to 16-sample blocks
    for (int n = 0; n < 16; n++) begin
      step($sformatf("clamp_s%0d", n), 1'b1, 3, -5, 1'b0, 7, n == 15);
    end
    checkOutput("clamp_I", out_I, 3);
`ifdef IQ_DECIM_ROUND_EN
    checkOutput("clamp_Q", out_Q, -5);
`else
    checkOutput("clamp_Q", out_Q, -5);
`endif

    // asynchronous reset for a half cycle in the middle of a block
    step("arst_s1", 1'b1, 1000, 1000, 1'b0, 2, 1'b0);
    step("arst_s2", 1'b1, 1000, 1000, 1'b0, 2, 1'b0);
    in_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    checkOutput("arst_valid", out_valid, 0);
    checkOutput("arst_I", out_I, 0);
    checkOutput("arst_Q", out_Q, 0);
    #2 rst_n = 1'b1;
    @(negedge clk);
    for (int n = 0; n < 4; n++) begin
      step($sformatf("arst_post%0d", n), 1'b1, 20, -20, 1'b0, 2, n == 3);
    end
    checkOutput("arst_blk_I", out_I, 20);
    checkOutput("arst_blk_Q", out_Q, -20);
    step("arst_idle", 1'b0, 0, 0, 1'b0, 2, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/iq_decim_avg.md
IQ_DECIM_AVG -- requirements
Module: iq_decim_avg

Interface
REQ-001 Parameter DW, default 14: I and Q sample width, signed two's complement.
REQ-002 Parameter LOG2_MAX, default 4: log2 of the largest decimation factor (max factor 16).
REQ-003 Port clk, input, 1: single clock; all state updates on rising edge.
REQ-004 Port rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 Port restart, input, 1: synchronous pulse that discards the partial block and re-aligns the block phase.
REQ-006 Port log2_dec, input, $clog2(LOG2_MAX+1): requested decimation exponent k; factor N = 2^k, legal range 0..LOG2_MAX.
REQ-007 Port in_valid, input, 1: in_I/in_Q hold a sample this cycle.
REQ-008 Port in_I, input, DW: in-phase sample, signed.
REQ-009 Port in_Q, input, DW: quadrature sample, signed.
REQ-010 Port out_valid, output, 1: single-cycle strobe marking a new averaged sample.
REQ-011 Port out_I, output, DW: averaged in-phase sample, signed.
REQ-012 Port out_Q, output, DW: averaged quadrature sample, signed.

Function
REQ-013 The block SHALL sum N consecutive accepted samples (in_valid=1) per channel and output the sum arithmetically shifted right by k.
REQ-014 Accumulators SHALL be DW+LOG2_MAX bits signed, so no overflow is possible for any legal k.
REQ-015 A sample counter SHALL count accepted samples 0..N-1 and wrap to 0 after the Nth; cycles with in_valid=0 SHALL leave all state unchanged.
REQ-016 On the first sample of a block, the accumulator SHALL load the sample rather than add to the previous sum.
REQ-017 k SHALL be latched when a block's first sample is accepted; changes to log2_dec mid-block SHALL take effect at the next block.
REQ-018 out_valid SHALL assert exactly one cycle after the Nth sample of a block is accepted; out_I/out_Q SHALL update in that same cycle and hold until the next strobe.
REQ-019 With k=0, every accepted sample SHALL appear unchanged on out_I/out_Q one cycle later, with out_valid=1.
REQ-020 A log2_dec value above LOG2_MAX SHALL be clamped to LOG2_MAX when latched.
REQ-021 If restart and in_valid are both high, the sample SHALL be taken as the first sample of a new block, and no output for the discarded block SHALL be produced.
REQ-022 If restart coincides with the Nth sample, that block's output SHALL NOT be produced.
REQ-023 I and Q SHALL share one counter and always stay block-aligned.

Reset
REQ-024 When rst_n=0, counter, accumulators, latched k, out_I, out_Q and out_valid SHALL clear to 0 immediately, independent of clk.
REQ-025 On rst_n deassertion, the first accepted sample SHALL start a new block; a reset mid-block SHALL discard that block with no output.

Configuration
REQ-026 With macro IQ_DECIM_ROUND_EN defined, the block SHALL add 2^(k-1) to the sum before shifting when k>0, giving round-half-up; the result never exceeds the DW range.
REQ-027 Without IQ_DECIM_ROUND_EN, the block SHALL truncate toward minus infinity (plain arithmetic shift), with no rounding logic present.

Structure
REQ-028 Package iq_decim_pkg SHALL hold the DW/LOG2_MAX defaults, the accumulator-width function and the log2_dec width constant.
REQ-029 Sub-module iq_decim_acc (one-channel accumulate/shift/round) SHALL be instantiated twice (I, Q); the counter and k latch SHALL stay in iq_decim_avg.

Verification
REQ-030 k=2, continuous valid, I=1,2,3,4 and Q=-1,-2,-3,-4: one out_valid one cycle after the 4th sample, with out_I=2, out_Q=-3 (truncated) or -2 (rounded).
REQ-031 k=4, DW=14, 16 samples of I=8191 and Q=-8192: out_I=8191, out_Q=-8192, with no wrap in either build.
REQ-032 k=2, with in_valid gapped by 3 idle cycles between samples 1,1,1,1: exactly one strobe (out_I=1), one cycle after the 4th valid sample.
REQ-033 Change log2_dec from 1 to 3 after the first sample of a block: that block closes after 2 samples, and the next block closes after 8.
REQ-034 restart pulsed with the 3rd sample of a k=2 block: no output for the old block, and the next strobe comes after 3 further samples.
REQ-035 rst_n low for one half-cycle mid-block: all outputs are 0 at once, and the first block after reset averages only post-reset samples.
